// File: rtl/lcore_irq_pkg.sv
// lcore_irq_pkg: shared port map, limits and priority encoder for the lcore interrupt controller
package lcore_irq_pkg;
  localparam int MAX_SRC         = 16;
  localparam int PORT_IRQ_STATUS = 4;
  localparam int PORT_IRQ_MASK   = 5;
  localparam int PORT_IRQ_CLR    = 32;
  localparam int PORT_IRQ_INSVC  = 33;
  localparam int VEC_BASE_DEF    = 48;
  typedef struct packed {
    logic       valid;
    logic [3:0] idx;
  } prio_t;
  function automatic prio_t prio_enc(input logic [MAX_SRC-1:0] v);
    prio_t r;
    r = '0;
    for (int i = MAX_SRC - 1; i >= 0; i--)
      if (v[i]) r = '{valid: 1'b1, idx: 4'(i)};
    return r;
  endfunction
endpackage

// File: rtl/lcore_irq_src.sv
// lcore_irq_src: per-source edge detector and pending bit; level sources pass src straight through
module lcore_irq_src (
  input  logic clock,
  input  logic reset_n,
  input  logic src,
  input  logic clr,
  input  logic ack_hit,
  input  logic is_edge,
  output logic pending
);
  logic prev, pend_q;
  // a fresh rising edge beats a same-cycle clear
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      prev   <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      prev   <= src;
      pend_q <= (src & ~prev) | (pend_q & ~(clr | ack_hit));
    end
  assign pending = is_edge ? pend_q : src;
endmodule

// File: rtl/lcore_irq_ctrl.sv
// lcore_irq_ctrl: prioritised interrupt controller; LCORE_IRQ_NEST_EN enables preemption of running handlers
module lcore_irq_ctrl
  import lcore_irq_pkg::*;
#(
  parameter int          NUM_SRC   = 8,
  parameter logic [15:0] EDGE_MASK = 16'h0000,
  parameter int          VEC_BASE  = VEC_BASE_DEF
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_SRC-1:0] src,
  input  logic [8:0]         io_port,
  input  logic [15:0]        wr_data,
  input  logic               wr_valid,
  output logic [15:0]        rd_data,
  output logic               irq,
  output logic [15:0]        vector,
  input  logic               irq_ack,
  input  logic               eoi
);
  logic [NUM_SRC-1:0] pending, mask, in_service, cand, ack_bit, eoi_bit;
  logic [15:0]        vec [NUM_SRC];
  logic [15:0]        vec_rd, vec_sel;
  logic [8:0]         vidx;
  logic               ack, wr_mask, wr_clr;
  prio_t              sel, top;
  assign cand    = pending & mask;
  assign sel     = prio_enc(MAX_SRC'(cand));
  assign top     = prio_enc(MAX_SRC'(in_service));
`ifdef LCORE_IRQ_NEST_EN
  assign irq     = sel.valid && (!top.valid || sel.idx < top.idx);
`else
  assign irq     = sel.valid && !top.valid;
`endif
  assign ack     = irq_ack && irq;
  assign ack_bit = ack ? NUM_SRC'(1) << sel.idx : '0;
  assign eoi_bit = (eoi && top.valid) ? NUM_SRC'(1) << top.idx : '0;
  assign wr_mask = wr_valid && io_port == 9'(PORT_IRQ_MASK);
  assign wr_clr  = wr_valid && io_port == 9'(PORT_IRQ_CLR);
  assign vidx    = io_port - 9'(VEC_BASE);
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    lcore_irq_src u_src (
      .clock   (clock),
      .reset_n (reset_n),
      .src     (src[i]),
      .clr     (wr_clr && wr_data[i]),
      .ack_hit (ack && sel.idx == 4'(i)),
      .is_edge (EDGE_MASK[i]),
      .pending (pending[i])
    );
  end
  // mask, in-service stack and vector table; eoi retires the pre-edge top while ack pushes the pre-edge sel
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      mask       <= '0;
      in_service <= '0;
      for (int i = 0; i < NUM_SRC; i++) vec[i] <= '0;
    end else begin
      if (wr_mask) mask <= wr_data[NUM_SRC-1:0];
      in_service <= (in_service & ~eoi_bit) | ack_bit;
      for (int i = 0; i < NUM_SRC; i++)
        if (wr_valid && vidx == 9'(i)) vec[i] <= wr_data;
    end
  // register read mux and selected-vector lookup
  always_comb begin
    vec_rd  = '0;
    vec_sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (vidx == 9'(i)) vec_rd = vec[i];
      if (sel.idx == 4'(i)) vec_sel = vec[i];
    end
    rd_data = io_port == 9'(PORT_IRQ_STATUS) ? 16'(cand) :
              io_port == 9'(PORT_IRQ_MASK)   ? 16'(mask) :
              io_port == 9'(PORT_IRQ_CLR)    ? 16'(pending) :
              io_port == 9'(PORT_IRQ_INSVC)  ? 16'(in_service) : vec_rd;
    vector  = irq ? vec_sel : '0;
  end
endmodule

// File: tb/tb_lcore_irq_ctrl.sv
// tb_lcore_irq_ctrl: directed test-plan scenarios plus randomized traffic against a behavioural model
module tb_lcore_irq_ctrl;
  localparam int          N  = 8;
  localparam logic [15:0] EM = 16'h00F4;
  localparam int          VB = 48;
  logic         clock = 0, reset_n = 0, wr_valid = 0, irq_ack = 0, eoi = 0;
  logic [N-1:0] src = '0;
  logic [8:0]   io_port = '0;
  logic [15:0]  wr_data = '0, rd_data, vector;
  logic         irq;
  int           n_chk = 0, n_err = 0;
  bit           m_pend [N], m_prev [N], m_insvc [N];
  logic [15:0]  m_mask;
  logic [15:0]  m_vec [N];

  always #10 clock = ~clock;

  lcore_irq_ctrl #(.NUM_SRC(N), .EDGE_MASK(EM), .VEC_BASE(VB)) dut (
    .clock(clock), .reset_n(reset_n), .src(src), .io_port(io_port), .wr_data(wr_data),
    .wr_valid(wr_valid), .rd_data(rd_data), .irq(irq), .vector(vector),
    .irq_ack(irq_ack), .eoi(eoi)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pbit(int i);
    return EM[i] ? m_pend[i] : src[i];
  endfunction

  function automatic int m_sel();
    for (int i = 0; i < N; i++) if (m_pbit(i) && m_mask[i]) return i;
    return -1;
  endfunction

  function automatic int m_top();
    for (int i = 0; i < N; i++) if (m_insvc[i]) return i;
    return N;
  endfunction

  function automatic bit m_irq();
    int s = m_sel();
`ifdef LCORE_IRQ_NEST_EN
    return s >= 0 && s < m_top();
`else
    return s >= 0 && m_top() == N;
`endif
  endfunction

  function automatic logic [15:0] m_vector();
    if (!m_irq()) return 16'h0;
    return m_vec[m_sel()];
  endfunction

  function automatic logic [15:0] m_rd(input logic [8:0] p);
    logic [15:0] r = '0;
    int pi = int'(p);
    for (int i = 0; i < N; i++) begin
      if (pi == 4)  r[i] = m_pbit(i) && m_mask[i];
      if (pi == 32) r[i] = m_pbit(i);
      if (pi == 33) r[i] = m_insvc[i];
    end
    if (pi == 5) r = m_mask;
    if (pi >= VB && pi < VB + N) r = m_vec[pi - VB];
    return r;
  endfunction

  task automatic m_reset();
    m_mask = '0;
    for (int i = 0; i < N; i++) begin
      m_pend[i] = 0; m_prev[i] = 0; m_insvc[i] = 0; m_vec[i] = '0;
    end
  endtask

  task automatic cyc(input logic [N-1:0] s, input bit wv, input logic [8:0] p,
                     input logic [15:0] d, input bit ak, input bit eo);
    src = s; wr_valid = wv; io_port = p; wr_data = d; irq_ack = ak; eoi = eo;
    #1;
    check("irq", 16'(irq), 16'(m_irq()));
    check("vector", vector, m_vector());
    check("rd_data", rd_data, m_rd(p));
  endtask

  task automatic adv();
    int  s, t;
    bit  ok;
    @(posedge clock);
    s  = m_sel();
    t  = m_top();
    ok = irq_ack && m_irq();
    for (int i = 0; i < N; i++) begin
      if (EM[i])
        m_pend[i] = (src[i] && !m_prev[i]) ||
                    (m_pend[i] && !((wr_valid && io_port == 32 && wr_data[i]) || (ok && s == i)));
      m_prev[i] = src[i];
    end
    if (eoi && t < N) m_insvc[t] = 0;
    if (ok) m_insvc[s] = 1;
    if (wr_valid && io_port == 5) m_mask = wr_data & 16'h00FF;
    if (wr_valid && int'(io_port) >= VB && int'(io_port) < VB + N) m_vec[int'(io_port) - VB] = wr_data;
    @(negedge clock);
  endtask

  task automatic run(input logic [N-1:0] s, input bit wv, input logic [8:0] p,
                     input logic [15:0] d, input bit ak, input bit eo);
    cyc(s, wv, p, d, ak, eo);
    adv();
  endtask

  initial begin
    m_reset();
    repeat (2) @(negedge clock);
    io_port = 9'd5;
    #1;
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_vector", vector, 16'h0);
    check("rst_mask", rd_data, 16'h0);
    reset_n = 1;

    run('0, 1, 9'd5, 16'h0005, 0, 0);
    run('0, 1, 9'd50, 16'h1234, 0, 0);
    run(8'h04, 0, 9'd4, 16'h0, 0, 0);
    cyc('0, 0, 9'd4, 16'h0, 0, 0);
    check("t1_status", rd_data, 16'h0004);
    check("t1_irq", 16'(irq), 16'h1);
    check("t1_vec", vector, 16'h1234);
    adv();
    run('0, 0, 9'd33, 16'h0, 1, 0);
    cyc('0, 0, 9'd33, 16'h0, 0, 0);
    check("t1_irq_after_ack", 16'(irq), 16'h0);
    check("t1_insvc", rd_data, 16'h0004);
    adv();
    run('0, 0, 9'd0, 16'h0, 0, 1);

    run('0, 1, 9'd49, 16'h3000, 0, 0);
    run('0, 1, 9'd51, 16'h4000, 0, 0);
    run('0, 1, 9'd5, 16'h000A, 0, 0);
    cyc(8'h0A, 0, 9'd0, 16'h0, 0, 0);
    check("t2_vec_hi", vector, 16'h3000);
    adv();
    run(8'h0A, 0, 9'd0, 16'h0, 1, 0);
    run(8'h08, 0, 9'd0, 16'h0, 0, 1);
    cyc(8'h08, 0, 9'd0, 16'h0, 0, 0);
    check("t2_vec_lo", vector, 16'h4000);
    adv();
    run(8'h08, 0, 9'd0, 16'h0, 1, 0);
    run('0, 0, 9'd0, 16'h0, 0, 1);

    run('0, 1, 9'd5, 16'h002A, 0, 0);
    run(8'h08, 0, 9'd0, 16'h0, 1, 0);
    cyc(8'h0A, 0, 9'd33, 16'h0, 0, 0);
    check("t3_insvc0", rd_data, 16'h0008);
`ifdef LCORE_IRQ_NEST_EN
    check("t3_preempt", 16'(irq), 16'h1);
`else
    check("t3_blocked", 16'(irq), 16'h0);
`endif
    adv();
    run(8'h0A, 0, 9'd0, 16'h0, 1, 0);
    cyc(8'h2A, 0, 9'd33, 16'h0, 0, 0);
    check("t3_low_blocked", 16'(irq), 16'h0);
`ifdef LCORE_IRQ_NEST_EN
    check("t3_insvc1", rd_data, 16'h000A);
`else
    check("t3_insvc1", rd_data, 16'h0008);
`endif
    adv();
    run(8'h2A, 0, 9'd0, 16'h0, 0, 1);
    cyc(8'h2A, 0, 9'd33, 16'h0, 0, 0);
`ifdef LCORE_IRQ_NEST_EN
    check("t3_insvc2", rd_data, 16'h0008);
`else
    check("t3_insvc2", rd_data, 16'h0000);
    check("t3_served", vector, 16'h3000);
`endif
    adv();
    run('0, 1, 9'd32, 16'h0020, 0, 1);
    run('0, 0, 9'd0, 16'h0, 0, 1);
    run('0, 0, 9'd0, 16'h0, 0, 1);

    run('0, 1, 9'd5, 16'h0001, 0, 0);
    run(8'h01, 0, 9'd0, 16'h0, 1, 0);
    cyc(8'h01, 0, 9'd0, 16'h0, 0, 1);
    check("t4_in_handler", 16'(irq), 16'h0);
    adv();
    cyc(8'h01, 0, 9'd0, 16'h0, 0, 0);
    check("t4_rerequest", 16'(irq), 16'h1);
    adv();
    run(8'h01, 1, 9'd32, 16'h0001, 0, 0);
    cyc(8'h01, 0, 9'd32, 16'h0, 0, 0);
    check("t4_w1c_level", rd_data, 16'h0001);
    adv();

    run('0, 1, 9'd5, 16'h00FF, 0, 0);
    run(8'h02, 0, 9'd0, 16'h0, 1, 0);
    cyc(8'h02, 0, 9'd33, 16'h0, 0, 0);
    check("t5_insvc", rd_data, 16'h0002);
    src = '0;
    reset_n = 0;
    #1;
    check("t5_irq", 16'(irq), 16'h0);
    check("t5_vector", vector, 16'h0);
    foreach (m_vec[k]) begin
      io_port = (k == 0) ? 9'd4 : (k == 1) ? 9'd5 : (k == 2) ? 9'd32 : (k == 3) ? 9'd33 : 9'(VB + k);
      #0.5;
      check("t5_reg", rd_data, 16'h0);
    end
    m_reset();
    @(negedge clock);
    reset_n = 1;

    for (int n = 0; n < 3000; n++) begin
      logic [8:0] p;
      int         r = $urandom_range(0, 5);
      p = (r == 0) ? 9'd4 : (r == 1) ? 9'd5 : (r == 2) ? 9'd32 : (r == 3) ? 9'd33 :
          (r == 4) ? 9'(VB + $urandom_range(0, N + 1)) : 9'($urandom);
      run(N'($urandom), $urandom_range(0, 3) == 0, p, 16'($urandom),
          $urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
